// File: rtl/max7219_pkg.sv
// Shared constants, shadow register file type and write-decode helper for the
// MAX7219 serial receiver.
package max7219_pkg;

    localparam int C_FRAME_WIDTH = 16;
    localparam int C_CNT_WIDTH   = 5;
    localparam logic [C_CNT_WIDTH-1:0] C_CNT_MAX = 5'd31;

    localparam logic [3:0] C_ADDR_NOOP       = 4'h0;
    localparam logic [3:0] C_ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] C_ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] C_ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] C_ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] C_ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] C_ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] C_ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] C_ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] C_ADDR_DECODE     = 4'h9;
    localparam logic [3:0] C_ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] C_ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] C_ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] C_ADDR_TEST       = 4'hF;

    typedef struct packed {
        logic [7:0][7:0] digit;
        logic [7:0]      decode;
        logic [3:0]      intensity;
        logic [2:0]      scan_limit;
        logic            shutdown_n;
        logic            display_test;
    } shadow_t;

    // Power-up state: everything clear, which leaves the device shut down.
    localparam shadow_t C_SHADOW_PWRUP = '0;

    function automatic shadow_t apply_write(input shadow_t cur,
                                            input logic [3:0] addr,
                                            input logic [7:0] data);
        shadow_t    nxt;
        logic [3:0] idx;
        nxt = cur;
        idx = addr - C_ADDR_DIGIT0;
        case (addr)
            C_ADDR_DECODE:     nxt.decode       = data;
            C_ADDR_INTENSITY:  nxt.intensity    = data[3:0];
            C_ADDR_SCAN_LIMIT: nxt.scan_limit   = data[2:0];
            C_ADDR_SHUTDOWN:   nxt.shutdown_n   = data[0];
            C_ADDR_TEST:       nxt.display_test = data[0];
            default: begin
                // No-op (0x0) and 0xD/0xE fall through untouched.
                if (addr >= C_ADDR_DIGIT0 && addr <= C_ADDR_DIGIT7) begin
                    nxt.digit[idx[2:0]] = data;
                end
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/max7219_rx_sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
// o_level is the synchronised level delayed to line up with o_rise.
module max7219_rx_sync_edge #(
    parameter int G_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [G_SYNC_STAGES-1:0] sync_q;
    logic [G_SYNC_STAGES-1:0] sync_d;
    logic                     prev_q;
    logic                     prev_d;
    logic                     rise_q;
    logic                     rise_d;

    always_comb begin
        sync_d = {sync_q[G_SYNC_STAGES-2:0], i_async};
        prev_d = sync_q[G_SYNC_STAGES-1];
        rise_d = sync_q[G_SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign o_level = prev_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 write-interface receiver: deserialises LOAD/DIN/CLK frames,
// decodes them and keeps a shadow copy of the device register file.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int G_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_max7219_load,
    input  logic        i_max7219_din,
    input  logic        i_max7219_clk,
    output logic        o_max7219_dout,
    output logic        o_wr_valid,
    output logic [3:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_frame_err,
    output logic [63:0] o_digit_reg,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_display_test
);

    logic clk_level;
    logic clk_rise;
    logic load_level;
    logic load_rise;
    logic din_s;

    logic [G_SYNC_STAGES-1:0] din_sync_q;
    logic [G_SYNC_STAGES-1:0] din_sync_d;

    max7219_rx_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_max7219_clk),
        .o_level (clk_level),
        .o_rise  (clk_rise)
    );

    max7219_rx_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_load_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_max7219_load),
        .o_level (load_level),
        .o_rise  (load_rise)
    );

    always_comb begin
        din_sync_d = {din_sync_q[G_SYNC_STAGES-2:0], i_max7219_din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync_q <= '0;
        end else begin
            din_sync_q <= din_sync_d;
        end
    end

    assign din_s = din_sync_q[G_SYNC_STAGES-1];

    // ---------------- shift register and bit counter ----------------
    logic [C_FRAME_WIDTH-1:0] shift_q;
    logic [C_FRAME_WIDTH-1:0] shift_d;
    logic [C_CNT_WIDTH-1:0]   cnt_q;
    logic [C_CNT_WIDTH-1:0]   cnt_d;
    logic                     dout_q;
    logic                     dout_d;
    logic                     shift_en;
    logic [C_FRAME_WIDTH-1:0] word_now;
    logic [C_CNT_WIDTH-1:0]   cnt_now;

    // load_level already reads high in the LOAD-rise cycle, so a coincident
    // CLK rise is still accepted and lands in the latched word.
    assign shift_en = clk_rise & clk_level & (~load_level | load_rise);

    always_comb begin
        word_now = shift_q;
        cnt_now  = cnt_q;
        dout_d   = dout_q;
        if (shift_en) begin
            word_now = {shift_q[C_FRAME_WIDTH-2:0], din_s};
            dout_d   = shift_q[C_FRAME_WIDTH-1];
            if (cnt_q != C_CNT_MAX) begin
                cnt_now = cnt_q + 1'b1;
            end
        end
        shift_d = word_now;
        cnt_d   = load_rise ? '0 : cnt_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    // ---------------- frame latch and decode ----------------
    logic       wr_valid_q;
    logic       wr_valid_d;
    logic       frame_err_q;
    logic       frame_err_d;
    logic [3:0] wr_addr_q;
    logic [3:0] wr_addr_d;
    logic [7:0] wr_data_q;
    logic [7:0] wr_data_d;

    always_comb begin
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (load_rise) begin
            if (cnt_now < C_CNT_WIDTH'(C_FRAME_WIDTH)) begin
                frame_err_d = 1'b1;
            end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = word_now[11:8];
                wr_data_d  = word_now[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // ---------------- shadow register file ----------------
    shadow_t shadow_q;
    shadow_t shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_valid_d) begin
            shadow_d = apply_write(shadow_q, wr_addr_d, wr_data_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= C_SHADOW_PWRUP;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign o_digit_reg[8*gi +: 8] = shadow_q.digit[gi];
    end

    assign o_max7219_dout = dout_q;
    assign o_wr_valid     = wr_valid_q;
    assign o_wr_addr      = wr_addr_q;
    assign o_wr_data      = wr_data_q;
    assign o_frame_err    = frame_err_q;
    assign o_decode_mode  = shadow_q.decode;
    assign o_intensity    = shadow_q.intensity;
    assign o_scan_limit   = shadow_q.scan_limit;
    assign o_shutdown_n   = shadow_q.shutdown_n;
    assign o_display_test = shadow_q.display_test;

endmodule
